// File: rtl/plugin_gray_packer_pkg.sv
// Shared lane geometry and FIFO entry type for the gray byte packer.
package RS5_pkg;
  localparam int GRAY_LANES    = 4;
  localparam int GRAY_BYTE_MSB = 31;
  localparam int LANE_W        = 8;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  nbytes;
  } packed_gray_t;
endpackage

// File: rtl/plugin_gray_fifo.sv
// Synchronous FIFO of packed gray words; head is read straight from the storage registers.
module plugin_gray_fifo
  import RS5_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  packed_gray_t push_data,
  input  logic         pop,
  output packed_gray_t head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  packed_gray_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/plugin_gray_packer.sv
// Packs four gray bytes per 32-bit word into an output FIFO, with flush of partial words.
// Optional binarization of each byte is enabled by defining PLUGIN_GRAY_THRESHOLD_EN.
module plugin_gray_packer
  import RS5_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] gray_pixel,
  input  logic [7:0]  threshold,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [2:0]  out_bytes,
  output logic [15:0] pixel_count,
  output logic        busy,
  output logic        done
);
  logic [1:0]   lane_cnt, lane_nxt;
  logic [31:0]  part_word, part_nxt, new_word;
  logic [2:0]   cnt_after;
  logic [7:0]   lane_byte;
  logic         flush_seen, done_q;
  logic         accept, flush_fire, push, full, empty;
  packed_gray_t push_data, head;

  logic unused_low;
  assign unused_low = ^gray_pixel[GRAY_BYTE_MSB-LANE_W:0];

`ifdef PLUGIN_GRAY_THRESHOLD_EN
  assign lane_byte = (gray_pixel[GRAY_BYTE_MSB -: LANE_W] >= threshold) ? 8'hFF : 8'h00;
`else
  logic unused_thr;
  assign unused_thr = ^threshold;
  assign lane_byte  = gray_pixel[GRAY_BYTE_MSB -: LANE_W];
`endif

  assign in_ready   = ~full;
  assign accept     = in_valid & in_ready;
  assign flush_fire = flush & ~flush_seen & ~full;
  assign cnt_after  = {1'b0, lane_cnt} + {2'b00, accept};

  for (genvar g = 0; g < GRAY_LANES; g++) begin : g_lane
    assign new_word[LANE_W*g +: LANE_W] = (accept && lane_cnt == 2'(g)) ? lane_byte
                                                                          : part_word[LANE_W*g +: LANE_W];
  end

  // A completed word and a flush in the same cycle collapse into one push.
  always_comb begin
    push             = 1'b0;
    lane_nxt         = lane_cnt;
    part_nxt         = part_word;
    push_data.word   = new_word;
    push_data.nbytes = cnt_after;
    if (accept) begin
      lane_nxt = lane_cnt + 2'd1;
      part_nxt = new_word;
    end
    if ((accept && lane_cnt == 2'd3) || (flush_fire && cnt_after != 3'd0)) begin
      push     = 1'b1;
      lane_nxt = 2'd0;
      part_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt    <= '0;
      part_word   <= '0;
      pixel_count <= '0;
      flush_seen  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      lane_cnt  <= lane_nxt;
      part_word <= part_nxt;
      done_q    <= flush_fire;
      if (accept) pixel_count <= pixel_count + 16'd1;
      // A held flush is served once; it must drop before it can fire again.
      if (!flush)          flush_seen <= 1'b0;
      else if (flush_fire) flush_seen <= 1'b1;
    end
  end

  plugin_gray_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready & ~empty),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = ~empty;
  assign out_word  = head.word;
  assign out_bytes = head.nbytes;
  assign busy      = (lane_cnt != 2'd0) | ~empty;
  assign done      = done_q;
endmodule

// File: tb/tb_plugin_gray_packer.sv
// Bench for plugin_gray_packer: queue-level reference model checked every cycle plus directed literals.
module tb_plugin_gray_packer;
  localparam int OUT_DEPTH = 2;

`ifdef PLUGIN_GRAY_THRESHOLD_EN
  localparam logic [31:0] E33 = 32'h0000FF00, E34 = 32'h00000000, EC = 32'h000000FF;
  localparam logic [31:0] ED0 = 32'h0, ED1 = 32'h0, ED2 = 32'h0, EE = 32'h0;
  localparam logic [31:0] ETH = 32'h00FFFF00, EWRAP = 32'hFFFFFFFF;
`else
  localparam logic [31:0] E33 = 32'h6000BF3F, E34 = 32'h00002211, EC = 32'h000000D5;
  localparam logic [31:0] ED0 = 32'h04030201, ED1 = 32'h08070605, ED2 = 32'h0C0B0A09, EE = 32'h04030201;
  localparam logic [31:0] ETH = 32'h00FF807F, EWRAP = 32'hFFFEFDFC;
`endif

  logic        clk, reset_n, in_valid, in_ready, flush, out_valid, out_ready, busy, done;
  logic [31:0] gray_pixel, out_word;
  logic [7:0]  threshold;
  logic [2:0]  out_bytes;
  logic [15:0] pixel_count;

  typedef struct { logic [31:0] w; logic [2:0] n; } wd_t;
  wd_t        mq[$];
  wd_t        got[$];
  logic [7:0] cur[$];
  int unsigned mcount;
  bit          fseen, mdone;
  int          n_tests = 0, n_fail = 0, done_cnt = 0;

  plugin_gray_packer #(.OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .gray_pixel(gray_pixel), .threshold(threshold), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_bytes(out_bytes), .pixel_count(pixel_count), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_lane(input logic [7:0] b);
`ifdef PLUGIN_GRAY_THRESHOLD_EN
    return (b >= threshold) ? 8'hFF : 8'h00;
`else
    return b;
`endif
  endfunction

  // Reference model: bytes collect in a list; a full list or a flush becomes a queued word.
  always @(posedge clk or negedge reset_n) begin : model
    bit  mfull, acc, fire, pop;
    wd_t nw;
    if (!reset_n) begin
      mq.delete(); cur.delete();
      mcount = 0; fseen = 0; mdone = 0;
    end else begin
      mfull = (mq.size() == OUT_DEPTH);
      acc   = in_valid && !mfull;
      fire  = flush && !fseen && !mfull;
      pop   = (mq.size() != 0) && out_ready;
      if (acc) begin
        cur.push_back(model_lane(gray_pixel[31:24]));
        mcount = (mcount + 1) % 65536;
      end
      if (pop) void'(mq.pop_front());
      if (cur.size() == 4 || (fire && cur.size() != 0)) begin
        nw.w = 32'h0;
        foreach (cur[i]) nw.w = nw.w | (32'(cur[i]) << (8 * i));
        nw.n = 3'(cur.size());
        mq.push_back(nw);
        cur.delete();
      end
      mdone = fire;
      if (!flush) fseen = 0;
      else if (fire) fseen = 1;
    end
  end

  always begin : compare
    wd_t e;
    @(negedge clk);
    #1;
    chk("in_ready",    32'(in_ready),    32'(mq.size() < OUT_DEPTH));
    chk("out_valid",   32'(out_valid),   32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_word",  out_word,         mq[0].w);
      chk("out_bytes", 32'(out_bytes),   32'(mq[0].n));
    end
    chk("pixel_count", 32'(pixel_count), mcount);
    chk("busy",        32'(busy),        32'(cur.size() != 0 || mq.size() != 0));
    chk("done",        32'(done),        32'(mdone));
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      e.w = out_word;
      e.n = out_bytes;
      got.push_back(e);
    end
  end

  task automatic send(input logic [31:0] p);
    int t = 0;
    in_valid   = 1'b1;
    gray_pixel = p;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; gray_pixel = '0; threshold = 8'h80;
    flush = 1'b0; out_ready = 1'b1;
    idle(2); #2;
    chk("rst_in_ready",    32'(in_ready),    32'd1);
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_pixel_count", 32'(pixel_count), 32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Four pixels into one full word
    got.delete();
    send(32'h3F3F3F00); send(32'hBFBFBF00); send(32'h00000000); send(32'h60606000);
    idle(4); #2;
    chk("w4_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      chk("w4_word",  got[0].w,        E33);
      chk("w4_bytes", 32'(got[0].n),   32'd4);
    end
    chk("w4_pixel_count", 32'(pixel_count), 32'd4);

    // Partial word flush
    got.delete(); done_cnt = 0;
    send(32'h11ABCDEF); send(32'h22123456);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(4); #2;
    chk("flush_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      chk("flush_word",  got[0].w,      E34);
      chk("flush_bytes", 32'(got[0].n), 32'd2);
    end
    chk("flush_done_pulses", 32'(done_cnt), 32'd1);

    // Held flush fires once; empty flush pushes nothing but still completes
    got.delete(); done_cnt = 0;
    send(32'hD5000000);
    flush = 1'b1;
    idle(5);
    flush = 1'b0;
    idle(2); #2;
    chk("held_done_pulses", 32'(done_cnt), 32'd1);
    chk("held_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      chk("held_word",  got[0].w,      EC);
      chk("held_bytes", 32'(got[0].n), 32'd1);
    end
    done_cnt = 0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(3); #2;
    chk("empty_flush_done", 32'(done_cnt), 32'd1);
    chk("empty_flush_nopush", 32'(got.size()), 32'd1);

    // Backpressure: 8 accepted fill the FIFO, the rest wait for drain
    pulse_reset();
    got.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send({8'(i), 24'h5A5A5A});
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1; gray_pixel = 32'h09000000;
    idle(3);
    chk("bp_stalled_count", 32'(pixel_count), 32'd8);
    out_ready = 1'b1;
    for (int i = 9; i <= 12; i++) send({8'(i), 24'h5A5A5A});
    idle(4); #2;
    chk("bp_words", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("bp_word0", got[0].w, ED0);
      chk("bp_word1", got[1].w, ED1);
      chk("bp_word2", got[2].w, ED2);
    end
    chk("bp_pixel_count", 32'(pixel_count), 32'd12);

    // Reset mid-word discards held bytes
    got.delete();
    send(32'hAA000000); send(32'hBB000000); send(32'hCC000000);
    pulse_reset();
    #1;
    chk("rr_in_ready", 32'(in_ready),    32'd1);
    chk("rr_busy",     32'(busy),        32'd0);
    chk("rr_count0",   32'(pixel_count), 32'd0);
    got.delete();
    @(negedge clk);
    for (int i = 1; i <= 4; i++) send({8'(i), 24'h0});
    idle(4); #2;
    chk("rr_words", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("rr_word", got[0].w, EE);
    chk("rr_pixel_count", 32'(pixel_count), 32'd4);

    // Threshold lanes (raw passthrough when binarization is not built in)
    got.delete();
    threshold = 8'h80;
    send(32'h7F000000); send(32'h80000000); send(32'hFF000000); send(32'h00000000);
    idle(4); #2;
    chk("thr_words", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("thr_word", got[0].w, ETH);

    // Counter wrap over 65536 pixels
    pulse_reset();
    got.delete();
    @(negedge clk);
    for (int i = 0; i < 65536; i++) send({8'(i), 24'h0});
    idle(4); #2;
    chk("wrap_pixel_count", 32'(pixel_count), 32'd0);
    chk("wrap_words",       32'(got.size()),  32'd16384);
    if (got.size() > 0) chk("wrap_last_word", got[got.size()-1].w, EWRAP);
    chk("wrap_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
